flex_updown_counter: RTL and testbench



---
 rtl/flex_updown_counter.sv | 144 ++++++++++++++
 tb/tb_flex_updown_counter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/flex_updown_counter.sv
// flex_updown_counter: parametrised up/down counter with a count range of
// 1..rollover_val. It can wrap or saturate at the bounds, take a synchronous
// parallel load, and uses a prescaler to divide the enable rate. Every flag
// is registered, so each flag is aligned to the same cycle as count_out.
module flex_updown_counter #(
  parameter int NUM_CNT_BITS  = 4,
  parameter int PRESCALE_BITS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     count_enable,
  input  logic                     count_down,
  input  logic                     sat_mode,
  input  logic                     load,
  input  logic [NUM_CNT_BITS-1:0]  load_val,
  input  logic [NUM_CNT_BITS-1:0]  rollover_val,
  input  logic [PRESCALE_BITS-1:0] prescale_val,
  output logic [NUM_CNT_BITS-1:0]  count_out,
  output logic                     rollover_flag,
  output logic                     wrap_pulse,
  output logic                     sat_flag
);

  localparam logic [NUM_CNT_BITS-1:0]  CNT_ONE   = NUM_CNT_BITS'(1);
  localparam logic [PRESCALE_BITS-1:0] PRESC_ONE = PRESCALE_BITS'(1);

  logic [NUM_CNT_BITS-1:0]  count_q, count_d;
  logic [PRESCALE_BITS-1:0] presc_q, presc_d;
  logic                     rollover_q, rollover_d;
  logic                     wrap_q, wrap_d;
  logic                     sat_q, sat_d;

  logic                     step;
  logic                     at_upper;
  logic                     at_lower;
  logic [NUM_CNT_BITS-1:0]  terminal;

  // A step happens only on an enabled cycle where the prescaler matches.
  // The match is an equality test, so if prescale_val is lowered below the
  // current prescaler value, the step waits until the prescaler wraps.
  assign step     = count_enable && (presc_q == prescale_val);
  assign at_upper = (count_q >= rollover_val);
  assign at_lower = (count_q <= CNT_ONE);
  assign terminal = count_down ? CNT_ONE : rollover_val;

  // Next-state logic. Priority per edge is clear > load > step > hold.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves
    // one unassigned. An unassigned path would infer a latch.
    count_d    = count_q;
    presc_d    = presc_q;
    wrap_d     = 1'b0;
    sat_d      = sat_q;
    rollover_d = rollover_q;

    if (clear) begin
      count_d    = '0;
      presc_d    = '0;
      sat_d      = 1'b0;
      rollover_d = 1'b0;
    end else begin
      if (load) begin
        count_d = load_val;
        presc_d = '0;
        sat_d   = 1'b0;
      end else if (count_enable) begin
        if (!step) begin
          presc_d = presc_q + PRESC_ONE;
        end else begin
          presc_d = '0;
          // +1 and -1 are applied only strictly inside the bounds, so the
          // count never overflows, even when a load left it out of range.
          // A step in wrap mode never blocks, so it clears sat_flag.
          unique case ({count_down, sat_mode})
            2'b00: begin
              sat_d = 1'b0;
              if (at_upper) begin
                count_d = CNT_ONE;
                wrap_d  = 1'b1;
              end else begin
                count_d = count_q + CNT_ONE;
              end
            end
            2'b01: begin
              if (at_upper) begin
                count_d = rollover_val;
                sat_d   = 1'b1;
              end else begin
                count_d = count_q + CNT_ONE;
                sat_d   = 1'b0;
              end
            end
            2'b10: begin
              sat_d = 1'b0;
              if (at_lower) begin
                count_d = rollover_val;
                wrap_d  = 1'b1;
              end else begin
                count_d = count_q - CNT_ONE;
              end
            end
            default: begin
              if (at_lower) begin
                sat_d = 1'b1;
              end else begin
                count_d = count_q - CNT_ONE;
                sat_d   = 1'b0;
              end
            end
          endcase
        end
      end
      // The flag tracks the next count against the direction sampled on
      // this edge, so it rises on the same edge the terminal value is reached.
      rollover_d = (count_d == terminal);
    end
  end

  // State register with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments, so every
    // register samples the values it had before this clock edge.
    if (rst) begin
      count_q    <= '0;
      presc_q    <= '0;
      rollover_q <= 1'b0;
      wrap_q     <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      count_q    <= count_d;
      presc_q    <= presc_d;
      rollover_q <= rollover_d;
      wrap_q     <= wrap_d;
      sat_q      <= sat_d;
    end
  end

  assign count_out     = count_q;
  assign rollover_flag = rollover_q;
  assign wrap_pulse    = wrap_q;
  assign sat_flag      = sat_q;

endmodule

// File: tb/tb_flex_updown_counter.sv
// Directed testbench for flex_updown_counter (NUM_CNT_BITS=4, PRESCALE_BITS=4).
// The bench drives inputs just after the falling edge and samples outputs on
// the falling edge, away from the active rising edge.
module tb_flex_updown_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic       count_enable;
  logic       count_down;
  logic       sat_mode;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] rollover_val;
  logic [3:0] prescale_val;
  logic [3:0] count_out;
  logic       rollover_flag;
  logic       wrap_pulse;
  logic       sat_flag;

  int checks   = 0;
  int failures = 0;

  flex_updown_counter #(.NUM_CNT_BITS(4), .PRESCALE_BITS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .count_enable (count_enable),
    .count_down   (count_down),
    .sat_mode     (sat_mode),
    .load         (load),
    .load_val     (load_val),
    .rollover_val (rollover_val),
    .prescale_val (prescale_val),
    .count_out    (count_out),
    .rollover_flag(rollover_flag),
    .wrap_pulse   (wrap_pulse),
    .sat_flag     (sat_flag)
  );

  always #5 clk = ~clk;

  // One rising edge, then return at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_load(input logic [3:0] v);
    load     = 1'b1;
    load_val = v;
    tick();
    load     = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; count_enable = 1'b0; count_down = 1'b0;
    sat_mode = 1'b0; load = 1'b0; load_val = '0; rollover_val = 4'd9;
    prescale_val = '0;
    #1;
    checks++;
    if ({count_out, rollover_flag, wrap_pulse, sat_flag} !== 7'd0) begin
      failures++;
      $display("FAIL reset_initial: got count=%0d rf=%b wp=%b sf=%b, want all 0",
               count_out, rollover_flag, wrap_pulse, sat_flag);
    end
    @(negedge clk);
    rst = 1'b0;
    do_load(4'd5);
    checks++;
    if (count_out !== 4'd5) begin
      failures++;
      $display("FAIL reset_preload: got count=%0d, want 5", count_out);
    end
    // Assert reset between edges. Its effect must show without a clock edge.
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({count_out, rollover_flag, wrap_pulse, sat_flag} !== 7'd0) begin
      failures++;
      $display("FAIL reset_async: got count=%0d rf=%b wp=%b sf=%b, want all 0",
               count_out, rollover_flag, wrap_pulse, sat_flag);
    end
    @(negedge clk);
    rst = 1'b0;
    count_enable = 1'b1;
    tick();
    checks++;
    if (count_out !== 4'd1) begin
      failures++;
      $display("FAIL reset_first_step: got count=%0d, want 1", count_out);
    end
    count_enable = 1'b0;
  endtask

  task automatic test_up_wrap_prescale();
    logic [3:0] exp_cnt [13] = '{0,0,1,1,1,2,2,2,3,3,3,1,1};
    logic       exp_rf  [13] = '{0,0,0,0,0,0,0,0,1,1,1,0,0};
    logic       exp_wp  [13] = '{0,0,0,0,0,0,0,0,0,0,0,1,0};
    clear = 1'b1; tick(); clear = 1'b0;
    rollover_val = 4'd3; prescale_val = 4'd2; count_down = 1'b0;
    sat_mode = 1'b0; count_enable = 1'b1;
    for (int i = 0; i < 13; i++) begin
      tick();
      checks++;
      if (count_out !== exp_cnt[i] || rollover_flag !== exp_rf[i] ||
          wrap_pulse !== exp_wp[i]) begin
        failures++;
        $display("FAIL up_wrap_prescale[%0d]: got count=%0d rf=%b wp=%b, want count=%0d rf=%b wp=%b",
                 i, count_out, rollover_flag, wrap_pulse, exp_cnt[i], exp_rf[i], exp_wp[i]);
      end
    end
    count_enable = 1'b0;
  endtask

  task automatic test_down_sat();
    logic [3:0] exp_cnt [4] = '{2,1,1,1};
    logic       exp_sf  [4] = '{0,0,1,1};
    logic       exp_rf  [4] = '{0,1,1,1};
    rollover_val = 4'd9; prescale_val = 4'd0; count_down = 1'b1;
    sat_mode = 1'b1; count_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) do_load(4'd2); else tick();
      checks++;
      if (count_out !== exp_cnt[i] || sat_flag !== exp_sf[i] ||
          rollover_flag !== exp_rf[i] || wrap_pulse !== 1'b0) begin
        failures++;
        $display("FAIL down_sat[%0d]: got count=%0d sf=%b rf=%b wp=%b, want count=%0d sf=%b rf=%b wp=0",
                 i, count_out, sat_flag, rollover_flag, wrap_pulse, exp_cnt[i], exp_sf[i], exp_rf[i]);
      end
    end
    count_enable = 1'b0;
  endtask

  task automatic test_down_wrap();
    logic [3:0] exp_cnt [4] = '{2,1,4,3};
    logic       exp_wp  [4] = '{0,0,1,0};
    logic       exp_rf  [4] = '{0,1,0,0};
    rollover_val = 4'd4; prescale_val = 4'd0; count_down = 1'b1;
    sat_mode = 1'b0; count_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) do_load(4'd2); else tick();
      checks++;
      if (count_out !== exp_cnt[i] || wrap_pulse !== exp_wp[i] ||
          rollover_flag !== exp_rf[i] || sat_flag !== 1'b0) begin
        failures++;
        $display("FAIL down_wrap[%0d]: got count=%0d wp=%b rf=%b sf=%b, want count=%0d wp=%b rf=%b sf=0",
                 i, count_out, wrap_pulse, rollover_flag, sat_flag, exp_cnt[i], exp_wp[i], exp_rf[i]);
      end
    end
    // With enable low, the count holds.
    count_enable = 1'b0;
    tick();
    checks++;
    if (count_out !== 4'd3 || wrap_pulse !== 1'b0) begin
      failures++;
      $display("FAIL hold_disabled: got count=%0d wp=%b, want count=3 wp=0",
               count_out, wrap_pulse);
    end
  endtask

  task automatic test_priority();
    rollover_val = 4'd9; prescale_val = 4'd2; count_down = 1'b0;
    sat_mode = 1'b0; count_enable = 1'b1;
    tick();  // advance the prescaler away from zero
    clear = 1'b1; load = 1'b1; load_val = 4'd7;
    tick();
    clear = 1'b0;
    checks++;
    if (count_out !== 4'd0 || {rollover_flag, wrap_pulse, sat_flag} !== 3'b000) begin
      failures++;
      $display("FAIL prio_clear: got count=%0d flags=%b, want count=0 flags=000",
               count_out, {rollover_flag, wrap_pulse, sat_flag});
    end
    tick();  // load still high, count_enable high
    load = 1'b0;
    checks++;
    if (count_out !== 4'd7) begin
      failures++;
      $display("FAIL prio_load: got count=%0d, want 7", count_out);
    end
    // The load cleared the prescaler, so the step lands on the third edge.
    tick(); tick();
    checks++;
    if (count_out !== 4'd7) begin
      failures++;
      $display("FAIL prio_presc_wait: got count=%0d, want 7", count_out);
    end
    tick();
    checks++;
    if (count_out !== 4'd8) begin
      failures++;
      $display("FAIL prio_presc_step: got count=%0d, want 8", count_out);
    end
    count_enable = 1'b0;
  endtask

  task automatic test_out_of_range();
    rollover_val = 4'd5; prescale_val = 4'd0; count_down = 1'b0;
    sat_mode = 1'b0; count_enable = 1'b1;
    do_load(4'd9);
    tick();
    checks++;
    if (count_out !== 4'd1 || wrap_pulse !== 1'b1) begin
      failures++;
      $display("FAIL oor_wrap: got count=%0d wp=%b, want count=1 wp=1",
               count_out, wrap_pulse);
    end
    sat_mode = 1'b1;
    do_load(4'd9);
    tick();
    checks++;
    if (count_out !== 4'd5 || sat_flag !== 1'b1 || rollover_flag !== 1'b1 ||
        wrap_pulse !== 1'b0) begin
      failures++;
      $display("FAIL oor_sat: got count=%0d sf=%b rf=%b wp=%b, want count=5 sf=1 rf=1 wp=0",
               count_out, sat_flag, rollover_flag, wrap_pulse);
    end
    count_enable = 1'b0;
  endtask

  task automatic test_back_to_back();
    rollover_val = 4'd1; prescale_val = 4'd0; count_down = 1'b0;
    sat_mode = 1'b0; count_enable = 1'b1;
    do_load(4'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (count_out !== 4'd1 || wrap_pulse !== 1'b1 || rollover_flag !== 1'b1) begin
        failures++;
        $display("FAIL back_to_back[%0d]: got count=%0d wp=%b rf=%b, want count=1 wp=1 rf=1",
                 i, count_out, wrap_pulse, rollover_flag);
      end
    end
    // With rollover_val=0 in up-saturate mode, the count is forced to 0.
    rollover_val = 4'd0; sat_mode = 1'b1;
    do_load(4'd3);
    tick();
    checks++;
    if (count_out !== 4'd0 || sat_flag !== 1'b1 || rollover_flag !== 1'b1) begin
      failures++;
      $display("FAIL zero_rollover_sat: got count=%0d sf=%b rf=%b, want count=0 sf=1 rf=1",
               count_out, sat_flag, rollover_flag);
    end
    count_enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_up_wrap_prescale();
    test_down_sat();
    test_down_wrap();
    test_priority();
    test_out_of_range();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
